mem_port_arbiter: RTL and testbench

//   Shares the 128x8 line-buffer memory between two requesters (video-fetch, host-loader).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_rd_tag_pipe.sv | 30 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the line-buffer port arbiter.
package mem_arb_pkg;

  localparam int MEM_AW     = 7;
  localparam int MEM_DW     = 8;
  localparam int MEM_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Shift register that follows each accepted read through the memory's read latency
// and presents its {valid, id} tag when the read data appears on mem_q.
module mem_rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MEM_RD_LAT
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [DEPTH];

  // NOTE: these are a handful of tag flops, so they take the reset and a reset drops
  // in-flight reads; a real storage array (like the line buffer) is left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      // NOTE: non-blocking so every stage shifts from the pre-edge value of its neighbour.
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of the 128x8 line buffer, with locked bursts.
// Define ARB_FIXED_PRIO_EN for fixed req0 priority instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = MEM_AW,
  parameter int DW     = MEM_DW,
  parameter int RD_LAT = MEM_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_last,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_last,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr_in,
  output logic [DW-1:0] mem_d,
  output logic [AW-1:0] mem_addr_out,
  input  logic [DW-1:0] mem_q
);

  arb_state_t    state;
  logic          prio;
  logic          gnt_any;
  logic          gnt_id;
  logic          sel_valid;
  logic          sel_we;
  logic          sel_last;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          accept;
  logic          rd_accept;
  logic [AW-1:0] rd_addr_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  rd_tag_t       tag_in;
  rd_tag_t       tag_out;

`ifdef ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  logic rr_ptr;

  // Pointer moves to the requester that did not just finish, so a waiting peer goes next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept && sel_last) begin
      rr_ptr <= ~gnt_id;
    end
  end

  assign prio = rr_ptr;
`endif

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    unique case (state)
      OWN0: begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end
      OWN1: begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
      default: begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = (req0_valid && req1_valid) ? prio : req1_valid;
      end
    endcase
    if (rst) gnt_any = 1'b0;
  end

  assign sel_valid = gnt_id ? req1_valid : req0_valid;
  assign sel_we    = gnt_id ? req1_we    : req0_we;
  assign sel_last  = gnt_id ? req1_last  : req0_last;
  assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;

  assign req0_ready = gnt_any & ~gnt_id;
  assign req1_ready = gnt_any &  gnt_id;
  assign accept     = gnt_any & sel_valid;
  assign rd_accept  = accept & ~sel_we;

  assign mem_we       = accept & sel_we;
  assign mem_addr_in  = sel_addr;
  assign mem_d        = sel_wdata;
  assign mem_addr_out = rd_accept ? sel_addr : rd_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (accept) begin
      if (sel_last) state <= IDLE;
      else          state <= gnt_id ? OWN1 : OWN0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
    end else if (rd_accept) begin
      rd_addr_q <= sel_addr;
    end
  end

  assign tag_in.valid = rd_accept;
  assign tag_in.id    = gnt_id;

  mem_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rsp0_valid = tag_out.valid & ~tag_out.id;
  assign rsp1_valid = tag_out.valid &  tag_out.id;

  // Data is passed straight through in the pulse cycle and held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rsp0_valid) rdata0_q <= mem_q;
      if (rsp1_valid) rdata1_q <= mem_q;
    end
  end

  assign rsp0_rdata = rsp0_valid ? mem_q : rdata0_q;
  assign rsp1_rdata = rsp1_valid ? mem_q : rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, and
// randomized traffic against a queue-based reference model (ARB_FIXED_PRIO_EN aware).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = MEM_AW;
  localparam int DW = MEM_DW;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_we, req0_last;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we, req1_last;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr_in, mem_addr_out;
  logic [DW-1:0] mem_d, mem_q;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_we      (req0_we),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req0_last    (req0_last),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req1_last    (req1_last),
    .rsp0_valid   (rsp0_valid),
    .rsp0_rdata   (rsp0_rdata),
    .rsp1_valid   (rsp1_valid),
    .rsp1_rdata   (rsp1_rdata),
    .mem_we       (mem_we),
    .mem_addr_in  (mem_addr_in),
    .mem_d        (mem_d),
    .mem_addr_out (mem_addr_out),
    .mem_q        (mem_q)
  );

  // Line buffer: write port and registered read address + registered data, both on clk.
  logic [DW-1:0] line_mem [2**AW] = '{default: 8'h00};
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (mem_we) line_mem[mem_addr_in] <= mem_d;
    ra_q  <= mem_addr_out;
    mem_q <= line_mem[ra_q];
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pq[$];
  pend_t         pn;
  logic [DW-1:0] shadow [2**AW] = '{default: 8'h00};
  int            m_own = -1;
  bit            m_rr  = 1'b0;
  logic [AW-1:0] m_aout = '0;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  int            cyc = 0;
  bit            chk_en = 1'b0;
  int            g;
  bit            acc, a_we, a_last, e_p0, e_p1;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_d;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_own = -1; m_rr = 1'b0; m_aout = '0; m_rd0 = '0; m_rd1 = '0;
      pq.delete();
      if (chk_en) begin
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rsp0", rsp0_valid, 0);
        check("rst_rsp1", rsp1_valid, 0);
      end
    end else begin
      if (m_own >= 0)                    g = m_own;
      else if (req0_valid && req1_valid) g = FIXED ? 0 : int'(m_rr);
      else if (req0_valid)               g = 0;
      else if (req1_valid)               g = 1;
      else                               g = -1;
      acc    = (g == 0 && req0_valid) || (g == 1 && req1_valid);
      a_we   = (g == 1) ? req1_we    : req0_we;
      a_last = (g == 1) ? req1_last  : req0_last;
      a_addr = (g == 1) ? req1_addr  : req0_addr;
      a_d    = (g == 1) ? req1_wdata : req0_wdata;
      e_p0 = 1'b0; e_p1 = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        if (pq[0].id) begin e_p1 = 1'b1; m_rd1 = pq[0].data; end
        else          begin e_p0 = 1'b1; m_rd0 = pq[0].data; end
        void'(pq.pop_front());
      end
      if (acc && !a_we) m_aout = a_addr;
      if (chk_en) begin
        check("m_ready0", req0_ready, (g == 0));
        check("m_ready1", req1_ready, (g == 1));
        check("m_mem_we", mem_we, (acc && a_we));
        check("m_rsp0_valid", rsp0_valid, e_p0);
        check("m_rsp1_valid", rsp1_valid, e_p1);
        check("m_rsp0_rdata", rsp0_rdata, m_rd0);
        check("m_rsp1_rdata", rsp1_rdata, m_rd1);
        check("m_mem_addr_out", mem_addr_out, m_aout);
        if (acc) begin
          check("m_mem_addr_in", mem_addr_in, a_addr);
          check("m_mem_d", mem_d, a_d);
        end
      end
      if (acc) begin
        if (a_we) begin
          shadow[a_addr] = a_d;
        end else begin
          pn.due = cyc + 2; pn.id = (g == 1); pn.data = shadow[a_addr];
          pq.push_back(pn);
        end
        if (a_last) begin
          m_own = -1;
          m_rr  = (g == 0);
        end else begin
          m_own = g;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          v0, we0, l0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1, we1, l1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0, r1, mwe, p0, p1;
    logic [DW-1:0] rd0, rd1;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v0, we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic l0,
    input logic v1, we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic l1,
    input logic r0, r1, mwe, p0, p1, input logic [DW-1:0] rd0, rd1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
    v.r0 = r0; v.r1 = r1; v.mwe = mwe; v.p0 = p0; v.p1 = p1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic drive0(input logic v, we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_last = l;
  endtask

  task automatic drive1(input logic v, we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_last = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int g0_cnt, g1_cnt;

  initial begin
    rst = 1'b1;
    drive0(1'b1, 1'b1, 7'h05, 8'hFF, 1'b1);
    drive1(1'b1, 1'b0, 7'h05, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    check("reset_ready0", req0_ready, 0);
    check("reset_ready1", req1_ready, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_rsp0_valid", rsp0_valid, 0);
    check("reset_rsp1_valid", rsp1_valid, 0);
    check("reset_rsp0_rdata", rsp0_rdata, 0);
    check("reset_rsp1_rdata", rsp1_rdata, 0);

    //             v0 we a0     d0     l0  v1 we a1     d1     l1  r0 r1 we p0 p1 rd0    rd1
    vecs[0]  = mk(1, 1, 7'h05, 8'hA5, 1,  0, 0, 7'h00, 8'h00, 1,  1, 0, 1, 0, 0, 8'h00, 8'h00);
    vecs[1]  = mk(1, 0, 7'h05, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  1, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[2]  = mk(0, 0, 7'h00, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[3]  = mk(0, 0, 7'h00, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1, 0, 8'hA5, 8'h00);
    vecs[4]  = mk(0, 0, 7'h00, 8'h00, 1,  1, 1, 7'h10, 8'h11, 0,  0, 1, 1, 0, 0, 8'hA5, 8'h00);
    vecs[5]  = mk(1, 0, 7'h00, 8'h00, 1,  1, 1, 7'h11, 8'h22, 0,  0, 1, 1, 0, 0, 8'hA5, 8'h00);
    vecs[6]  = mk(1, 0, 7'h00, 8'h00, 1,  1, 1, 7'h12, 8'h33, 0,  0, 1, 1, 0, 0, 8'hA5, 8'h00);
    vecs[7]  = mk(1, 0, 7'h00, 8'h00, 1,  1, 1, 7'h13, 8'h44, 1,  0, 1, 1, 0, 0, 8'hA5, 8'h00);
    vecs[8]  = mk(1, 0, 7'h11, 8'h00, 1,  1, 0, 7'h00, 8'h00, 1,  1, 0, 0, 0, 0, 8'hA5, 8'h00);
    vecs[9]  = mk(0, 0, 7'h00, 8'h00, 1,  1, 0, 7'h13, 8'h00, 1,  0, 1, 0, 0, 0, 8'hA5, 8'h00);
    vecs[10] = mk(0, 0, 7'h00, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1, 0, 8'h22, 8'h00);
    vecs[11] = mk(0, 0, 7'h00, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  0, 0, 0, 0, 1, 8'h22, 8'h44);
    vecs[12] = mk(1, 1, 7'h7F, 8'h3C, 1,  0, 0, 7'h00, 8'h00, 1,  1, 0, 1, 0, 0, 8'h22, 8'h44);
    vecs[13] = mk(1, 0, 7'h7F, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  1, 0, 0, 0, 0, 8'h22, 8'h44);
    vecs[14] = mk(1, 1, 7'h00, 8'h5A, 1,  0, 0, 7'h00, 8'h00, 1,  1, 0, 1, 0, 0, 8'h22, 8'h44);
    vecs[15] = mk(1, 0, 7'h00, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  1, 0, 0, 1, 0, 8'h3C, 8'h44);
    vecs[16] = mk(1, 0, 7'h05, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  1, 0, 0, 0, 0, 8'h3C, 8'h44);
    vecs[17] = mk(0, 0, 7'h00, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1, 0, 8'h5A, 8'h44);
    vecs[18] = mk(0, 0, 7'h00, 8'h00, 1,  0, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1, 0, 8'hA5, 8'h44);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive0(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0, vecs[i].l0);
      drive1(vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1, vecs[i].l1);
      @(negedge clk);
      check($sformatf("vec%0d_ready0", i), req0_ready, vecs[i].r0);
      check($sformatf("vec%0d_ready1", i), req1_ready, vecs[i].r1);
      check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].mwe);
      check($sformatf("vec%0d_rsp0_valid", i), rsp0_valid, vecs[i].p0);
      check($sformatf("vec%0d_rsp1_valid", i), rsp1_valid, vecs[i].p1);
      check($sformatf("vec%0d_rsp0_rdata", i), rsp0_rdata, vecs[i].rd0);
      check($sformatf("vec%0d_rsp1_rdata", i), rsp1_rdata, vecs[i].rd1);
      next_cycle();
    end

    // Contention from reset: single reads on both ports every cycle.
    chk_en = 1'b1;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive0(1'b1, 1'b0, 7'h05, 8'h00, 1'b1);
    drive1(1'b1, 1'b0, 7'h13, 8'h00, 1'b1);
    g0_cnt = 0; g1_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req0_ready && req0_valid) g0_cnt++;
      if (req1_ready && req1_valid) g1_cnt++;
      next_cycle();
    end
    check("contend_req0_grants", g0_cnt, FIXED ? 8 : 4);
    check("contend_req1_grants", g1_cnt, FIXED ? 0 : 4);
    drive0(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    drive1(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    repeat (3) next_cycle();

    // Reset one cycle after a read accept that opened a burst.
    drive0(1'b1, 1'b0, 7'h05, 8'h00, 1'b0);
    next_cycle();
    rst = 1'b1;
    drive0(1'b1, 1'b1, 7'h05, 8'hEE, 1'b1);
    repeat (2) next_cycle();
    rst = 1'b0;
    drive0(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    repeat (3) next_cycle();
    drive1(1'b1, 1'b0, 7'h05, 8'h00, 1'b1);
    @(negedge clk);
    check("post_rst_idle_req1_ready", req1_ready, 1);
    next_cycle();
    drive1(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    repeat (3) next_cycle();

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      drive0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
             8'($urandom), $urandom_range(0, 2) != 0);
      drive1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
             8'($urandom), $urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      next_cycle();
    end
    rst = 1'b0;
    drive0(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    drive1(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    repeat (6) next_cycle();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
